slc3_mem_responder: RTL and testbench

- Memory-side responder for the SLC-3 CPU memory interface; serves the CPU's MAR/MDR reads and writes.
- Strobes are active-low: CE, OE, WE, UB, LB.
- Models a word-addressed SRAM with programmable wait states and a one-cycle Mem_Ready completion pulse.
- Sits between the CPU core and the on-chip RAM, in both the synthesis top and the simulation top.

---
 rtl/slc3_mem_pkg.sv | 10 +
 rtl/slc3_sram_array.sv | 27 ++
 rtl/slc3_mem_responder.sv | 139 +++++++++++++
 tb/tb_slc3_mem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
package slc3_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, HOLD} state_t;

    typedef logic [15:0] word_t;

    localparam word_t IO_ADDR = 16'hFFFF;

endpackage

// File: rtl/slc3_sram_array.sv
// DEPTH x 16 word array: synchronous byte-enabled write, combinational read.
module slc3_sram_array #(
    parameter int DEPTH     = 1024,
    parameter int AW        = $clog2(DEPTH),
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);
    import slc3_mem_pkg::*;

    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            if (be[1]) mem[addr][15:8] <= wdata[15:8];
            if (be[0]) mem[addr][7:0]  <= wdata[7:0];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory-side responder: wait-state FSM, request capture and optional IO map.
// Optional feature: define SLC3_IO_MAP_EN to map address 16'hFFFF to SW / IO_Out.
module slc3_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [15:0]       Data_to_SRAM,
    input  logic              CE,
    input  logic              OE,
    input  logic              WE,
    input  logic              UB,
    input  logic              LB,
    output logic [15:0]       Data_from_SRAM,
    output logic              Mem_Ready,
    output logic              Addr_Err,
    input  logic [9:0]        SW,
    output logic [15:0]       IO_Out
);
    import slc3_mem_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    state_t            state, state_nxt;
    logic [CW-1:0]     wait_cnt;
    logic [ADDR_W-1:0] cap_addr;
    word_t             cap_data;
    logic              cap_ub, cap_lb, cap_write;

    logic  req, req_write, strobes_off;
    logic  at_resp, in_range, is_io, arr_we, err_hit;
    word_t arr_rdata, rd_word;

    assign strobes_off = CE | (OE & WE);
    assign req         = ~CE & (~WE | ~OE);
    assign req_write   = ~CE & ~WE;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = (WAIT_STATES > 0) ? BUSY : RESP;
            BUSY: begin
                if (strobes_off)          state_nxt = IDLE;
                else if (wait_cnt == '0)  state_nxt = RESP;
            end
            RESP: state_nxt = HOLD;
            HOLD: if (strobes_off) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The IO address is decoded ahead of the range check so it never flags an error.
    always_comb begin
        at_resp  = (state == RESP);
        in_range = ({1'b0, cap_addr} < (ADDR_W + 1)'(DEPTH));
`ifdef SLC3_IO_MAP_EN
        is_io    = (cap_addr == IO_ADDR);
`else
        is_io    = 1'b0;
`endif
        arr_we   = at_resp & cap_write & in_range & ~is_io;
        err_hit  = at_resp & ~in_range & ~is_io;
        rd_word  = '0;
        if (is_io)         rd_word = {6'b0, SW};
        else if (in_range) rd_word = arr_rdata;
    end

    // Request fields are latched at the accepting edge so the CPU may move on.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wait_cnt  <= '0;
            cap_addr  <= '0;
            cap_data  <= '0;
            cap_ub    <= 1'b1;
            cap_lb    <= 1'b1;
            cap_write <= 1'b0;
        end else if (state == IDLE && req) begin
            wait_cnt  <= CW'(WAIT_STATES - 1);
            cap_addr  <= ADDR;
            cap_data  <= Data_to_SRAM;
            cap_ub    <= UB;
            cap_lb    <= LB;
            cap_write <= req_write;
        end else if (state == BUSY && wait_cnt != '0) begin
            wait_cnt  <= wait_cnt - CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Data_from_SRAM <= '0;
            Mem_Ready      <= 1'b0;
            Addr_Err       <= 1'b0;
        end else begin
            Mem_Ready <= at_resp;
            if (at_resp && !cap_write) Data_from_SRAM <= rd_word;
            if (err_hit)               Addr_Err       <= 1'b1;
        end
    end

`ifdef SLC3_IO_MAP_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            IO_Out <= '0;
        end else if (at_resp && cap_write && is_io) begin
            if (!cap_ub) IO_Out[15:8] <= cap_data[15:8];
            if (!cap_lb) IO_Out[7:0]  <= cap_data[7:0];
        end
    end
`else
    logic unused_sw;
    assign unused_sw = ^SW;
    assign IO_Out    = '0;
`endif

    slc3_sram_array #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (Clk),
        .we    (arr_we),
        .be    ({~cap_ub, ~cap_lb}),
        .addr  (cap_addr[AW-1:0]),
        .wdata (cap_data),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed self-checking bench for slc3_mem_responder (WAIT_STATES=2, DEPTH=1024).
module tb_slc3_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] ADDR = '0;
    logic [15:0] Data_to_SRAM = '0;
    logic        CE = 1'b1, OE = 1'b1, WE = 1'b1, UB = 1'b1, LB = 1'b1;
    logic [15:0] Data_from_SRAM;
    logic        Mem_Ready, Addr_Err;
    logic [9:0]  SW = '0;
    logic [15:0] IO_Out;

    int testsRun = 0;
    int testsFailed = 0;

    int          rdyCyc;
    logic [15:0] rdData, rdHeld;
    logic        rdyAgain;
    int          rdyCount;

    slc3_mem_responder #(
        .ADDR_W      (16),
        .DEPTH       (1024),
        .WAIT_STATES (2),
        .INIT_FILE   ("")
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .CE             (CE),
        .OE             (OE),
        .WE             (WE),
        .UB             (UB),
        .LB             (LB),
        .Data_from_SRAM (Data_from_SRAM),
        .Mem_Ready      (Mem_Ready),
        .Addr_Err       (Addr_Err),
        .SW             (SW),
        .IO_Out         (IO_Out)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction; the request inputs are scrambled right after acceptance.
    task automatic applyStimulus(input logic oe_n, input logic we_n, input logic [15:0] addr,
                                 input logic [15:0] data, input logic ub_n, input logic lb_n,
                                 output int rdy_cyc, output logic [15:0] rd_data,
                                 output logic rdy_again, output logic [15:0] rd_held);
        @(negedge Clk);
        ADDR = addr; Data_to_SRAM = data; UB = ub_n; LB = lb_n;
        OE = oe_n; WE = we_n; CE = 1'b0;
        rdy_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (Mem_Ready) begin
                rdy_cyc = c;
                break;
            end
            if (c == 0) begin
                ADDR = addr ^ 16'h0005; Data_to_SRAM = ~data; UB = ~ub_n; LB = ~lb_n;
            end
        end
        rd_data = Data_from_SRAM;
        @(negedge Clk);
        rdy_again = Mem_Ready;
        rd_held   = Data_from_SRAM;
        CE = 1'b1; OE = 1'b1; WE = 1'b1;
        @(negedge Clk);
    endtask

    task automatic doWrite(input logic [15:0] addr, input logic [15:0] data,
                           input logic ub_n, input logic lb_n);
        applyStimulus(1'b1, 1'b0, addr, data, ub_n, lb_n, rdyCyc, rdData, rdyAgain, rdHeld);
    endtask

    task automatic doRead(input logic [15:0] addr);
        applyStimulus(1'b0, 1'b1, addr, 16'h0000, 1'b1, 1'b1, rdyCyc, rdData, rdyAgain, rdHeld);
    endtask

    initial begin
        Reset_n = 1'b0;
        #3;
        checkOutput("reset_data", {16'h0, Data_from_SRAM}, 32'h0);
        checkOutput("reset_ready", {31'h0, Mem_Ready}, 32'h0);
        checkOutput("reset_err", {31'h0, Addr_Err}, 32'h0);
        checkOutput("reset_io", {16'h0, IO_Out}, 32'h0);
        #14;
        Reset_n = 1'b1;

        doWrite(16'h0031, 16'hBEEF, 1'b0, 1'b0);
        checkOutput("wr_ready_cycle", rdyCyc, 32'd3);
        checkOutput("wr_single_pulse", {31'h0, rdyAgain}, 32'h0);

        doRead(16'h0031);
        checkOutput("rd_ready_cycle", rdyCyc, 32'd3);
        checkOutput("rd_data", {16'h0, rdData}, 32'h0000BEEF);
        checkOutput("rd_data_hold", {16'h0, rdHeld}, 32'h0000BEEF);
        checkOutput("rd_single_pulse", {31'h0, rdyAgain}, 32'h0);

        doWrite(16'h0040, 16'h1234, 1'b0, 1'b0);
        doWrite(16'h0040, 16'hABCD, 1'b1, 1'b0);
        doRead(16'h0040);
        checkOutput("lane_low_only", {16'h0, rdData}, 32'h000012CD);
        doWrite(16'h0040, 16'h5600, 1'b0, 1'b1);
        doRead(16'h0040);
        checkOutput("lane_high_only", {16'h0, rdData}, 32'h000056CD);
        doWrite(16'h0040, 16'hFFFF, 1'b1, 1'b1);
        checkOutput("lane_none_ready", rdyCyc, 32'd3);
        doRead(16'h0040);
        checkOutput("lane_none_data", {16'h0, rdData}, 32'h000056CD);

        // OE and WE both low must be a write, leaving the read register untouched.
        applyStimulus(1'b0, 1'b0, 16'h0002, 16'h00FF, 1'b0, 1'b0, rdyCyc, rdData, rdyAgain, rdHeld);
        checkOutput("oewe_ready", rdyCyc, 32'd3);
        checkOutput("oewe_no_read", {16'h0, rdData}, 32'h000056CD);
        doRead(16'h0002);
        checkOutput("oewe_data", {16'h0, rdData}, 32'h000000FF);

        doWrite(16'h0010, 16'h1111, 1'b0, 1'b0);
        @(negedge Clk);
        ADDR = 16'h0010; Data_to_SRAM = 16'h5555; UB = 1'b0; LB = 1'b0;
        OE = 1'b1; WE = 1'b0; CE = 1'b0;
        @(negedge Clk);
        CE = 1'b1; WE = 1'b1;
        rdyCount = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (Mem_Ready) rdyCount++;
        end
        checkOutput("abort_no_ready", rdyCount, 32'd0);
        doRead(16'h0010);
        checkOutput("abort_no_commit", {16'h0, rdData}, 32'h00001111);

        doWrite(16'h0020, 16'h2222, 1'b0, 1'b0);
        @(negedge Clk);
        ADDR = 16'h0020; Data_to_SRAM = 16'h7777; UB = 1'b0; LB = 1'b0;
        OE = 1'b1; WE = 1'b0; CE = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checkOutput("busy_rst_data", {16'h0, Data_from_SRAM}, 32'h0);
        checkOutput("busy_rst_ready", {31'h0, Mem_Ready}, 32'h0);
        repeat (3) @(negedge Clk);
        CE = 1'b1; WE = 1'b1;
        Reset_n = 1'b1;
        doRead(16'h0020);
        checkOutput("busy_rst_no_commit", {16'h0, rdData}, 32'h00002222);

`ifdef SLC3_IO_MAP_EN
        SW = 10'b0000110001;
        doRead(16'hFFFF);
        checkOutput("io_read", {16'h0, rdData}, 32'h00000031);
        doWrite(16'hFFFF, 16'h00AA, 1'b0, 1'b0);
        checkOutput("io_write", {16'h0, IO_Out}, 32'h000000AA);
        doWrite(16'hFFFF, 16'h5500, 1'b0, 1'b1);
        checkOutput("io_write_lane", {16'h0, IO_Out}, 32'h000055AA);
        checkOutput("io_no_err", {31'h0, Addr_Err}, 32'h0);
`else
        checkOutput("io_tied_off", {16'h0, IO_Out}, 32'h0);
`endif

        doWrite(16'h0000, 16'h0A0A, 1'b0, 1'b0);
        checkOutput("err_clear_before", {31'h0, Addr_Err}, 32'h0);
        doRead(16'h0400);
        checkOutput("oor_ready_cycle", rdyCyc, 32'd3);
        checkOutput("oor_read_zero", {16'h0, rdData}, 32'h0);
        checkOutput("oor_single_pulse", {31'h0, rdyAgain}, 32'h0);
        checkOutput("oor_err_set", {31'h0, Addr_Err}, 32'h1);
        doWrite(16'h0400, 16'h9999, 1'b0, 1'b0);
        checkOutput("oor_write_ready", rdyCyc, 32'd3);
        doRead(16'h0000);
        checkOutput("oor_write_dropped", {16'h0, rdData}, 32'h00000A0A);
        checkOutput("oor_err_sticky", {31'h0, Addr_Err}, 32'h1);
`ifndef SLC3_IO_MAP_EN
        doRead(16'hFFFF);
        checkOutput("ffff_oor_zero", {16'h0, rdData}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
